// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 instruction-set constants.
// Holds the icode encodings, the per-class ifun limits, the instruction length
// classes and a helper that tells whether an icode carries a register byte.
// Imported by the instruction-memory encoder and by the fetch stage, so both
// agree on the length and legality of every instruction.
package y86_pkg;

    // Instruction codes (high nibble of byte 0).
    localparam logic [3:0] IcodeNop    = 4'h0;
    localparam logic [3:0] IcodeHalt   = 4'h1;
    localparam logic [3:0] IcodeRrmovl = 4'h2;  // also the CMOVxx family
    localparam logic [3:0] IcodeIrmovl = 4'h3;
    localparam logic [3:0] IcodeRmmovl = 4'h4;
    localparam logic [3:0] IcodeMrmovl = 4'h5;
    localparam logic [3:0] IcodeAlu    = 4'h6;
    localparam logic [3:0] IcodeJxx    = 4'h7;
    localparam logic [3:0] IcodeCall   = 4'h8;
    localparam logic [3:0] IcodeRet    = 4'h9;
    localparam logic [3:0] IcodePushl  = 4'hA;
    localparam logic [3:0] IcodePopl   = 4'hB;

    // Highest legal function code per instruction class.
    localparam logic [3:0] MaxIfunAlu  = 4'd3;
    localparam logic [3:0] MaxIfunJxx  = 4'd6;
    localparam logic [3:0] MaxIfunCmov = 4'd6;

    // Encoded lengths in bytes.
    localparam logic [3:0] LenBare     = 4'd1;   // opcode byte only
    localparam logic [3:0] LenReg      = 4'd2;   // opcode + register byte
    localparam logic [3:0] LenDest     = 4'd9;   // opcode + 8-byte destination
    localparam logic [3:0] LenRegConst = 4'd10;  // opcode + register byte + 8-byte constant

    // Encoder sequencing states.
    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } enc_state_e;

    // True when the encoding places a {rA,rB} byte right after the opcode byte.
    function automatic logic has_reg_byte(input logic [3:0] icode);
        logic r;
        r = 1'b0;
        case (icode)
            IcodeRrmovl, IcodeIrmovl, IcodeRmmovl, IcodeMrmovl,
            IcodeAlu, IcodePushl, IcodePopl: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_instr_len.sv
// imem_instr_len: combinational Y86 instruction length/legality decoder.
// Ports:
//   icode  in  4  instruction code
//   ifun   in  4  function code
//   info   out 5  {legal, length[3:0]}; length is 0 for unknown icodes
module imem_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic [4:0] info
);

    logic       legal;
    logic [3:0] len;

    always_comb begin
        legal = 1'b0;
        len   = 4'd0;
        case (icode)
            IcodeNop, IcodeHalt, IcodeRet: begin
                legal = (ifun == 4'h0);
                len   = LenBare;
            end
            IcodeRrmovl: begin
                legal = (ifun <= MaxIfunCmov);
                len   = LenReg;
            end
            IcodeAlu: begin
                legal = (ifun <= MaxIfunAlu);
                len   = LenReg;
            end
            IcodePushl, IcodePopl: begin
                legal = (ifun == 4'h0);
                len   = LenReg;
            end
            IcodeJxx: begin
                legal = (ifun <= MaxIfunJxx);
                len   = LenDest;
            end
            IcodeCall: begin
                legal = (ifun == 4'h0);
                len   = LenDest;
            end
            IcodeIrmovl, IcodeRmmovl, IcodeMrmovl: begin
                legal = (ifun == 4'h0);
                len   = LenRegConst;
            end
            default: begin
                legal = 1'b0;
                len   = 4'd0;
            end
        endcase
    end

    assign info = {legal, len};

endmodule

// File: rtl/imem_encoder.sv
// imem_encoder: serialises Y86 instructions into byte writes to an
// instruction memory.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i, start_addr_i  load the write pointer (honoured only when idle)
//   in_valid_i/in_ready_o  instruction handshake
//   icode_i, ifun_i, rA_i, rB_i, valC_i  instruction fields
//   wr_en_o, wr_addr_o, wr_data_o        byte write port (zero when idle)
//   next_pc_o              write pointer = valP of last completed instruction
//   err_invalid_o          one-cycle pulse: illegal icode/ifun rejected
//   err_mem_o              one-cycle pulse: instruction would overflow memory
//   instr_count_o          number of instructions fully written (wrapping)
module imem_encoder
    import y86_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [63:0]      start_addr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       icode_i,
    input  logic [3:0]       ifun_i,
    input  logic [3:0]       rA_i,
    input  logic [3:0]       rB_i,
    input  logic [63:0]      valC_i,
    output logic             wr_en_o,
    output logic [63:0]      wr_addr_o,
    output logic [7:0]       wr_data_o,
    output logic [63:0]      next_pc_o,
    output logic             err_invalid_o,
    output logic             err_mem_o,
    output logic [CNT_W-1:0] instr_count_o
);

    enc_state_e       state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             err_inv_q, err_inv_d;
    logic             err_mem_q, err_mem_d;

    // Latched instruction fields, loaded on acceptance.
    logic [3:0]       icode_q, ifun_q, ra_q, rb_q, len_q;
    logic [63:0]      valc_q;
    logic             fields_ld;

    logic [4:0]       in_info;
    logic             in_legal;
    logic [3:0]       in_len;
    logic [64:0]      in_end;
    logic             in_fits;
    logic             hs;

    imem_instr_len u_instr_len (
        .icode (icode_i),
        .ifun  (ifun_i),
        .info  (in_info)
    );

    assign in_legal = in_info[4];
    assign in_len   = in_info[3:0];

    // 65-bit sum so a pointer close to 2^64 cannot wrap into range.
    assign in_end  = {1'b0, pc_q} + {61'd0, in_len};
    assign in_fits = (in_end <= 65'(MEM_BYTES));

    // start_i takes priority, so it also masks ready.
    assign in_ready_o = (state_q == StIdle) && !rst_i && !start_i;
    assign hs         = in_valid_i && in_ready_o;

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_inv_d = 1'b0;
        err_mem_d = 1'b0;
        fields_ld = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    pc_d = start_addr_i;
                end else if (hs) begin
                    // Illegality is reported ahead of a range failure.
                    if (!in_legal) begin
                        err_inv_d = 1'b1;
                    end else if (!in_fits) begin
                        err_mem_d = 1'b1;
                    end else begin
                        state_d   = StEmit;
                        idx_d     = 4'd0;
                        fields_ld = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (idx_q == len_q - 4'd1) begin
                    state_d = StIdle;
                    idx_d   = 4'd0;
                    pc_d    = pc_q + {60'd0, len_q};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_inv_q <= 1'b0;
            err_mem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_inv_q <= err_inv_d;
            err_mem_q <= err_mem_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            icode_q <= '0;
            ifun_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            len_q   <= '0;
            valc_q  <= '0;
        end else if (fields_ld) begin
            icode_q <= icode_i;
            ifun_q  <= ifun_i;
            ra_q    <= rA_i;
            rb_q    <= rB_i;
            len_q   <= in_len;
            valc_q  <= valC_i;
        end
    end

    // Byte selection: opcode, optional register byte, then valC LSB first.
    logic       has_reg;
    logic [2:0] valc_idx;
    logic [7:0] byte_sel;

    always_comb begin
        has_reg  = has_reg_byte(icode_q);
        valc_idx = 3'd0;
        byte_sel = 8'h00;
        if (idx_q == 4'd0) begin
            byte_sel = {icode_q, ifun_q};
        end else if (has_reg && (idx_q == 4'd1)) begin
            byte_sel = {ra_q, rb_q};
        end else begin
            valc_idx = has_reg ? 3'(idx_q - 4'd2) : 3'(idx_q - 4'd1);
            byte_sel = valc_q[{valc_idx, 3'b000} +: 8];
        end
    end

    // Reset cuts the write strobe in the same cycle so an aborted instruction
    // leaves no partial byte behind.
    logic emit_active;
    assign emit_active = (state_q == StEmit) && !rst_i;

    always_comb begin
        wr_en_o   = emit_active;
        wr_addr_o = '0;
        wr_data_o = '0;
        if (emit_active) begin
            wr_addr_o = pc_q + {60'd0, idx_q};
            wr_data_o = byte_sel;
        end
    end

    assign next_pc_o     = pc_q;
    assign instr_count_o = cnt_q;
    assign err_invalid_o = err_inv_q;
    assign err_mem_o     = err_mem_q;

endmodule

// File: doc/imem_encoder.md
IMEM_ENCODER -- requirements
Module: imem_encoder

Interface
REQ-001 Parameter MEM_BYTES, default 1024: size of the instruction memory being written, in bytes.
REQ-002 Parameter CNT_W, default 32: width of the instruction counter.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 start_i  input  1  loads the write pointer from start_addr_i.
REQ-006 start_addr_i  input  64  base byte address for the next instruction.
REQ-007 in_valid_i  input  1  an instruction is presented on the field inputs.
REQ-008 in_ready_o  output  1  encoder can accept an instruction.
REQ-009 icode_i, ifun_i, rA_i, rB_i  input  4 each  instruction fields.
REQ-010 valC_i  input  64  constant or destination word.
REQ-011 wr_en_o  output  1  byte write strobe to instruction memory.
REQ-012 wr_addr_o  output  64  byte address of the write.
REQ-013 wr_data_o  output  8  byte written.
REQ-014 next_pc_o  output  64  current write pointer; equals valP of the last instruction fully written.
REQ-015 err_invalid_o  output  1  one-cycle pulse: instruction rejected because icode/ifun is illegal.
REQ-016 err_mem_o  output  1  one-cycle pulse: instruction rejected because it does not fit in memory.
REQ-017 instr_count_o  output  CNT_W  number of instructions fully written.

Function
REQ-018 The encoder SHALL use icode values NOP=0, HALT=1, RRMOVL=2, IRMOVL=3, RMMOVL=4, MRMOVL=5, ALU=6, JXX=7, CALL=8, RET=9, PUSHL=A, POPL=B.
REQ-019 Legality SHALL be: ALU ifun 0-3; JXX and RRMOVL/CMOV ifun 0-6; all other listed icodes ifun 0 only; icode C-F illegal.
REQ-020 Lengths SHALL be: NOP/HALT/RET 1; RRMOVL/ALU/PUSHL/POPL 2; JXX/CALL 9; IRMOVL/RMMOVL/MRMOVL 10.
REQ-021 Byte order SHALL be: byte0 = {icode,ifun}; byte1 = {rA,rB} when the instruction has a register byte; then valC_i little-endian (LSB first) in 8 bytes.
REQ-022 rA_i and rB_i SHALL be written as given, with no forcing to F.
REQ-023 FSM states SHALL be IDLE and EMIT; in_ready_o = 1 only in IDLE and not in reset.
REQ-024 A handshake (in_valid_i & in_ready_o) SHALL latch all fields and go to EMIT if the instruction is legal and next_pc_o + length <= MEM_BYTES.
REQ-025 EMIT SHALL assert wr_en_o for exactly length consecutive cycles, starting the cycle after acceptance, with wr_addr_o = next_pc_o + byte index.
REQ-026 After the last byte, next_pc_o SHALL advance by length and instr_count_o SHALL increment (wrapping at 2^CNT_W); the FSM SHALL return to IDLE.
REQ-027 An illegal handshake SHALL write no bytes, leave the pointer and counter unchanged, stay in IDLE, and pulse err_invalid_o in the following cycle.
REQ-028 An out-of-range handshake SHALL do the same but pulse err_mem_o; when an instruction is both illegal and out of range, only err_invalid_o SHALL pulse.
REQ-029 The address sum SHALL be computed with 65-bit width, so a pointer near 2^64 is rejected and does not wrap.
REQ-030 start_i in IDLE SHALL set next_pc_o = start_addr_i the next cycle; start_i in EMIT SHALL be ignored.
REQ-031 When start_i and a handshake occur in the same IDLE cycle, start_i SHALL win and the instruction SHALL NOT be accepted; in_ready_o is 0 while start_i = 1.
REQ-032 wr_data_o and wr_addr_o SHALL be 0 whenever wr_en_o = 0.

Reset
REQ-033 On rst_i, the FSM SHALL enter IDLE and all outputs SHALL read 0 the next cycle (next_pc_o, instr_count_o, wr_*, err_*, in_ready_o).
REQ-034 Reset during EMIT SHALL abort the instruction with no further writes and no counter update.

Structure
REQ-035 The icode localparams and the length/legality constants SHALL live in a shared package, y86_pkg, which the fetch stage also imports.
REQ-036 A combinational sub-module imem_instr_len SHALL take (icode, ifun) and return {legal, length[3:0]}; it SHALL be reusable by fetch.

Verification
REQ-037 Reset, start_addr=0, ALU 0x60 rA=1 rB=2 -> writes 60,12 at addresses 0,1; next_pc=2; count=1.
REQ-038 IRMOVL 0x30 rA=F rB=3 valC=0x0123456789ABCDEF at pc=2 -> 10 writes: 30,F3,EF,CD,AB,89,67,45,23,01 at 2..11; next_pc=12.
REQ-039 JXX ifun=7 (0x77), then ALU ifun=4 (0x64) -> err_invalid pulses twice; no wr_en; next_pc unchanged.
REQ-040 start_addr=MEM_BYTES-5 then CALL (length 9) -> err_mem pulse, no writes; a following HALT (0x10) is written at 1019.
REQ-041 Back-to-back in_valid held high with NOP, RET -> bytes 00 then 90, one IDLE cycle between them, count+2.
REQ-042 rst_i asserted mid-EMIT of a RMMOVL -> wr_en=0 next cycle; next_pc=0; count=0.
